alu_issue_sched: RTL and testbench

- Shares the single-cycle integer ALU among NUM_REQ issue requesters (integer issue queue, system/CSR path, ...).
- Arbitrates round-robin into a one-entry output register feeding the ALU operand stage.
- Serialises fence/CSR-stalling instructions: after one is issued, no further grants until write-back signals completion.
- Sits between the read-register stage and the ALU in the execution stage.

---
 rtl/drac_pkg.sv | 45 ++++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/alu_issue_sched.sv | 150 +++++++++++++++
 tb/tb_alu_issue_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared execution-stage types for the ALU issue scheduler and its arbiter.
// Provides the read-register -> ALU instruction payload, the functional unit
// encoding, the scheduler state encoding and the serialising-instruction test.
package drac_pkg;

    localparam int unsigned ALU_SCHED_MAX_REQ = 4;

    localparam int unsigned PC_W    = 40;
    localparam int unsigned GL_W    = 6;
    localparam int unsigned ITYPE_W = 7;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned PREG_W  = 6;

    typedef enum logic [2:0] {
        UNIT_ALU,
        UNIT_DIV,
        UNIT_MUL,
        UNIT_BRANCH,
        UNIT_MEM,
        UNIT_CONTROL,
        UNIT_SYSTEM
    } functional_unit_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [GL_W-1:0]    gl_index;
        functional_unit_t   unit;
        logic [ITYPE_W-1:0] instr_type;
        logic               stall_csr_fence;
        logic [DATA_W-1:0]  data_rs1;
        logic [DATA_W-1:0]  data_rs2;
        logic [PREG_W-1:0]  prd;
    } rr_exe_arith_instr_t;

    typedef enum logic {
        RUN,
        FENCE_WAIT
    } sched_state_t;

    // Instructions that must drain through write-back before anything else issues.
    function automatic logic is_serialising(input rr_exe_arith_instr_t instr);
        return instr.stall_csr_fence || (instr.unit == UNIT_SYSTEM);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for a shared execution unit.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   req_i         : request vector
//   en_i          : grants allowed this cycle (grant implies transfer)
//   gnt_c_o       : combinational one-hot grant
// The pointer moves to winner+1 whenever a grant is issued, otherwise holds.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_c_o
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan from the pointer, wrapping modulo N; first valid requester wins.
    always_comb begin
        gnt_c_o = '0;
        ptr_d   = ptr_q;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PTR_W'((32'(ptr_q) + off) % N);
            if (en_i && !found && req_i[idx]) begin
                gnt_c_o[idx] = 1'b1;
                found        = 1'b1;
                ptr_d        = (32'(idx) == N - 1) ? '0 : idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Issue scheduler sharing the single-cycle integer ALU among NUM_REQ requesters.
// Round-robin arbitration into a one-entry output register; serialising
// (fence/CSR/system) instructions block further grants until write-back
// signals completion or the fence timeout expires.
// Ports:
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   flush_i        : discard buffered instruction and pending fence wait
//   req_valid_i    : per-requester instruction valid
//   req_instr_i    : per-requester instruction payload
//   req_ready_o    : one-hot grant (combinational), transfer on valid&ready
//   alu_valid_o    : output register holds an instruction
//   alu_instr_o    : instruction toward the ALU operand stage
//   alu_ready_i    : ALU/write-back accepts the output instruction
//   fence_done_i   : write-back retired the serialising instruction
//   fence_wait_o   : scheduler waiting on a serialising instruction
//   timeout_o      : one-cycle pulse when the fence wait times out
module alu_issue_sched
    import drac_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned FENCE_TIMEOUT = 1023
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              flush_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  rr_exe_arith_instr_t [NUM_REQ-1:0] req_instr_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic                              alu_valid_o,
    output rr_exe_arith_instr_t               alu_instr_o,
    input  logic                              alu_ready_i,
    input  logic                              fence_done_i,
    output logic                              fence_wait_o,
    output logic                              timeout_o
);

    localparam int unsigned CNT_W = $clog2(FENCE_TIMEOUT + 1);

    if (NUM_REQ < 2 || NUM_REQ > ALU_SCHED_MAX_REQ) begin : g_bad_num_req
        $error("alu_issue_sched: NUM_REQ out of range");
    end

    sched_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic                alu_valid_q, alu_valid_d;
    rr_exe_arith_instr_t instr_q, instr_d;

    logic                arb_en;
    logic [NUM_REQ-1:0]  gnt;
    logic                transfer;
    rr_exe_arith_instr_t sel_instr;

    // Grants only when running, not flushing, and the output register can
    // take a new entry. Reset is included so no grant is shown while held.
    assign arb_en = rstn_i && !flush_i && (state_q == RUN)
                    && (!alu_valid_q || alu_ready_i);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .req_i   (req_valid_i),
        .en_i    (arb_en),
        .gnt_c_o (gnt)
    );

    assign transfer    = |gnt;
    assign req_ready_o = gnt;

    // One-hot payload select.
    always_comb begin
        sel_instr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_instr = req_instr_i[i];
            end
        end
    end

    // Next-state: output register, fence FSM and timeout counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        alu_valid_d = alu_valid_q;
        instr_d     = instr_q;

        if (alu_valid_q && alu_ready_i) begin
            alu_valid_d = 1'b0;
        end
        if (transfer) begin
            alu_valid_d = 1'b1;
            instr_d     = sel_instr;
        end

        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (transfer && is_serialising(sel_instr)) begin
                    state_d = FENCE_WAIT;
                end
            end
            FENCE_WAIT: begin
                if (fence_done_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(FENCE_TIMEOUT - 1)) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase

        // Flush overrides everything; the buffered instruction is dropped.
        if (flush_i) begin
            alu_valid_d = 1'b0;
            state_d     = RUN;
            cnt_d       = '0;
            timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            alu_valid_q <= 1'b0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            alu_valid_q <= alu_valid_d;
            instr_q     <= instr_d;
        end
    end

    assign alu_valid_o  = alu_valid_q;
    assign alu_instr_o  = instr_q;
    assign fence_wait_o = (state_q == FENCE_WAIT);
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched (NUM_REQ=2, FENCE_TIMEOUT=8).
module tb_alu_issue_sched;
    import drac_pkg::*;

    logic                      clk;
    logic                      rstn;
    logic                      flush;
    logic [1:0]                req_valid;
    rr_exe_arith_instr_t [1:0] req_instr;
    logic [1:0]                req_ready;
    logic                      alu_valid;
    rr_exe_arith_instr_t       alu_instr;
    logic                      alu_ready;
    logic                      fence_done;
    logic                      fence_wait;
    logic                      timeout;

    int n_checks;
    int n_fail;

    alu_issue_sched #(
        .NUM_REQ       (2),
        .FENCE_TIMEOUT (8)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .flush_i      (flush),
        .req_valid_i  (req_valid),
        .req_instr_i  (req_instr),
        .req_ready_o  (req_ready),
        .alu_valid_o  (alu_valid),
        .alu_instr_o  (alu_instr),
        .alu_ready_i  (alu_ready),
        .fence_done_i (fence_done),
        .fence_wait_o (fence_wait),
        .timeout_o    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rr_exe_arith_instr_t mk(input int gl, input logic fence,
                                               input functional_unit_t u);
        rr_exe_arith_instr_t r;
        r                 = '0;
        r.gl_index        = 6'(gl);
        r.stall_csr_fence = fence;
        r.unit            = u;
        r.data_rs1        = 64'(gl) + 64'h100;
        r.pc              = 40'(gl) * 40'd4;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rstn       = 1'b1;
        flush      = 1'b0;
        req_valid  = '0;
        req_instr  = '0;
        alu_ready  = 1'b0;
        fence_done = 1'b0;

        // Reset values
        #2 rstn = 1'b0;
        step();
        check("rst_valid", 64'(alu_valid), 64'h0);
        check("rst_instr", 64'(alu_instr.gl_index), 64'h0);
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_fwait", 64'(fence_wait), 64'h0);
        check("rst_tmo",   64'(timeout), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // S1: both valid, full throughput, alternating grants
        req_valid = 2'b11;
        alu_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_instr[0] = mk((c % 2 == 0) ? c : c + 1, 1'b0, UNIT_ALU);
            req_instr[1] = mk((c % 2 == 1) ? c : c + 1, 1'b0, UNIT_ALU);
            #1;
            check("s1_gnt", 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            check("s1_valid", 64'(alu_valid), 64'(c > 0));
            if (c > 0) check("s1_gl", 64'(alu_instr.gl_index), 64'(c - 1));
            step();
        end
        req_valid = 2'b00;
        #1;
        check("s1_last_gl", 64'(alu_instr.gl_index), 64'd5);
        check("s1_last_rdy", 64'(req_ready), 64'h0);
        step();
        #1;
        check("s1_drained", 64'(alu_valid), 64'h0);
        step();

        // S2: backpressure holds instruction stable, then back-to-back
        req_valid    = 2'b01;
        req_instr[0] = mk(10, 1'b0, UNIT_ALU);
        alu_ready    = 1'b0;
        #1;
        check("s2_gnt0", 64'(req_ready), 64'h1);
        step();
        for (int k = 0; k < 3; k++) begin
            req_instr[0] = mk(11, 1'b0, UNIT_ALU);
            #1;
            check("s2_hold_valid", 64'(alu_valid), 64'h1);
            check("s2_hold_gl", 64'(alu_instr.gl_index), 64'd10);
            check("s2_hold_rs1", alu_instr.data_rs1, 64'h10a);
            check("s2_hold_rdy", 64'(req_ready), 64'h0);
            step();
        end
        alu_ready = 1'b1;
        #1;
        check("s2_refill_rdy", 64'(req_ready), 64'h1);
        check("s2_refill_gl", 64'(alu_instr.gl_index), 64'd10);
        step();
        req_instr[0] = mk(12, 1'b0, UNIT_ALU);
        #1;
        check("s2_b2b_gl", 64'(alu_instr.gl_index), 64'd11);
        check("s2_b2b_rdy", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        #1;
        check("s2_last_gl", 64'(alu_instr.gl_index), 64'd12);
        step();
        #1;
        check("s2_drained", 64'(alu_valid), 64'h0);
        step();

        // S3: fence from requester 1 blocks requester 0 until fence_done
        req_valid    = 2'b11;
        req_instr[1] = mk(20, 1'b1, UNIT_ALU);
        req_instr[0] = mk(21, 1'b0, UNIT_ALU);
        #1;
        check("s3_gnt1", 64'(req_ready), 64'h2);
        check("s3_fwait0", 64'(fence_wait), 64'h0);
        step();
        for (int k = 1; k <= 5; k++) begin
            req_valid  = 2'b01;
            fence_done = (k == 5);
            #1;
            check("s3_blk_rdy", 64'(req_ready), 64'h0);
            check("s3_fwait", 64'(fence_wait), 64'h1);
            if (k == 1) check("s3_fence_gl", 64'(alu_instr.gl_index), 64'd20);
            if (k == 2) check("s3_fence_drain", 64'(alu_valid), 64'h0);
            step();
        end
        fence_done = 1'b0;
        #1;
        check("s3_resume_fw", 64'(fence_wait), 64'h0);
        check("s3_resume_rdy", 64'(req_ready), 64'h1);
        check("s3_no_tmo", 64'(timeout), 64'h0);
        step();
        req_valid = 2'b00;
        #1;
        check("s3_gl", 64'(alu_instr.gl_index), 64'd21);
        step();

        // S4: system instruction, no fence_done -> timeout after 8 cycles
        req_valid    = 2'b11;
        req_instr[1] = mk(30, 1'b0, UNIT_SYSTEM);
        req_instr[0] = mk(31, 1'b0, UNIT_ALU);
        #1;
        check("s4_gnt1", 64'(req_ready), 64'h2);
        step();
        for (int k = 1; k <= 8; k++) begin
            req_valid = 2'b01;
            #1;
            check("s4_fwait", 64'(fence_wait), 64'h1);
            check("s4_tmo_lo", 64'(timeout), 64'h0);
            check("s4_blk_rdy", 64'(req_ready), 64'h0);
            step();
        end
        #1;
        check("s4_tmo_pulse", 64'(timeout), 64'h1);
        check("s4_fwait_fall", 64'(fence_wait), 64'h0);
        check("s4_resume_rdy", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        #1;
        check("s4_tmo_single", 64'(timeout), 64'h0);
        check("s4_gl", 64'(alu_instr.gl_index), 64'd31);
        step();

        // S5: flush while holding an instruction in FENCE_WAIT
        req_valid    = 2'b10;
        req_instr[1] = mk(40, 1'b1, UNIT_ALU);
        req_instr[0] = mk(41, 1'b0, UNIT_ALU);
        alu_ready    = 1'b0;
        #1;
        check("s5_gnt1", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b01;
        #1;
        check("s5_held", 64'(alu_valid), 64'h1);
        check("s5_held_gl", 64'(alu_instr.gl_index), 64'd40);
        check("s5_fwait", 64'(fence_wait), 64'h1);
        step();
        flush     = 1'b1;
        alu_ready = 1'b1;
        #1;
        check("s5_flush_rdy", 64'(req_ready), 64'h0);
        step();
        flush = 1'b0;
        #1;
        check("s5_post_valid", 64'(alu_valid), 64'h0);
        check("s5_post_fwait", 64'(fence_wait), 64'h0);
        check("s5_post_rdy", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        #1;
        check("s5_gl", 64'(alu_instr.gl_index), 64'd41);
        step();

        // S6: async reset mid-burst
        req_valid    = 2'b11;
        req_instr[0] = mk(50, 1'b0, UNIT_ALU);
        req_instr[1] = mk(51, 1'b0, UNIT_ALU);
        #1;
        check("s6_gnt1", 64'(req_ready), 64'h2);
        step();
        #1;
        check("s6_gnt0", 64'(req_ready), 64'h1);
        check("s6_valid", 64'(alu_valid), 64'h1);
        rstn = 1'b0;
        #1;
        check("s6_rst_valid", 64'(alu_valid), 64'h0);
        check("s6_rst_gl", 64'(alu_instr.gl_index), 64'h0);
        check("s6_rst_rdy", 64'(req_ready), 64'h0);
        check("s6_rst_fwait", 64'(fence_wait), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("s6_first_gnt", 64'(req_ready), 64'h1);
        step();
        #1;
        check("s6_first_gl", 64'(alu_instr.gl_index), 64'd50);
        check("s6_first_valid", 64'(alu_valid), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
